// File: rtl/div_pkg.sv
// div_pkg: state encoding and counter sizing shared by the sequential divider.
package div_pkg;
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] CALC   = 2'd1;
   localparam logic [1:0] FINISH = 2'd2;
   function automatic int cnt_width(input int w);
      return $clog2(w);
   endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring step, shifting in a dividend bit and subtracting when possible.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   p_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH:0]   p_o,
   output logic             q_o
);
   logic [WIDTH+1:0] t;
   assign t   = {p_i, bit_i};
   assign q_o = t >= {2'b0, d_i};
   assign p_o = (WIDTH+1)'(q_o ? t - {2'b0, d_i} : t);
endmodule

// File: rtl/seq_signed_divider.sv
// seq_signed_divider: multi-cycle signed divider with C semantics, one quotient bit per clock.
module seq_signed_divider
   import div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic             overflow
);
   localparam int CW = cnt_width(WIDTH);
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, quo_q, quo_d, rem_q, rem_d, r_src;
   logic [WIDTH:0]   p_q, p_d, p_nxt;
   logic             s1_q, s1_d, s2_q, s2_d, busy_q, busy_d, done_q, done_d;
   logic             dbz_q, dbz_d, ovf_q, ovf_d, q_bit;
   div_step #(.WIDTH(WIDTH)) u_step (
      .p_i  (p_q),
      .bit_i(a_q[WIDTH-1]),
      .d_i  (b_q),
      .p_o  (p_nxt),
      .q_o  (q_bit)
   );
   // a_q holds the dividend magnitude and fills with quotient bits as it shifts out
   assign r_src = b_q == '0 ? a_q : p_q[WIDTH-1:0];
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      p_d     = p_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;
      if (state_q == IDLE) begin
         if (start) begin
            a_d     = in1[WIDTH-1] ? -in1 : in1;
            b_d     = in2[WIDTH-1] ? -in2 : in2;
            s1_d    = in1[WIDTH-1];
            s2_d    = in2[WIDTH-1];
            p_d     = '0;
            cnt_d   = CW'(WIDTH-1);
            busy_d  = 1'b1;
            dbz_d   = 1'b0;
            ovf_d   = 1'b0;
            state_d = in2 == '0 ? FINISH : CALC;
         end
      end else if (state_q == CALC) begin
         p_d     = p_nxt;
         a_d     = {a_q[WIDTH-2:0], q_bit};
         cnt_d   = cnt_q - 1'b1;
         state_d = cnt_q == '0 ? FINISH : CALC;
      end else if (state_q == FINISH) begin
         quo_d   = b_q == '0 ? '1 : (s1_q ^ s2_q ? -a_q : a_q);
         rem_d   = s1_q ? -r_src : r_src;
         dbz_d   = b_q == '0;
         // a divisor of magnitude 1 leaves the quotient magnitude equal to the dividend magnitude
         ovf_d   = s1_q & s2_q & (b_q == WIDTH'(1)) & (a_q == MIN);
         done_d  = 1'b1;
         busy_d  = 1'b0;
         state_d = IDLE;
      end else begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         p_q     <= '0;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         p_q     <= p_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
      end
   end
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;
endmodule

// File: tb/tb_seq_signed_divider.sv
// tb_seq_signed_divider: random and directed checks of the divider against a C-semantics model.
module tb_seq_signed_divider;
   localparam int W = 32;
   localparam int MIN = 32'h80000000;
   logic clk = 1'b0;
   logic rst, start, busy, done, div_by_zero, overflow;
   logic [W-1:0] in1, in2, quotient, remainder;
   int n_chk = 0, n_err = 0, cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   seq_signed_divider #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in1        (in1),
      .in2        (in2),
      .quotient   (quotient),
      .remainder  (remainder),
      .busy       (busy),
      .done       (done),
      .div_by_zero(div_by_zero),
      .overflow   (overflow)
   );
   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic model(input int a, input int b, output int q, output int r, output logic dz, output logic ov);
      dz = b == 0;
      ov = a == MIN && b == -1;
      q  = dz ? -1 : int'(longint'(a) / longint'(b));
      r  = dz ? a : int'(longint'(a) % longint'(b));
   endtask
   task automatic run(input int a, input int b);
      int eq, er, n;
      logic edz, eov, bz;
      string pre;
      pre = $sformatf("%0d/%0d", a, b);
      model(a, b, eq, er, edz, eov);
      @(negedge clk);
      in1   = a;
      in2   = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bz = 1'b1;
      n  = 0;
      while (!done && n < 100) begin
         bz &= busy;
         @(negedge clk);
         n++;
      end
      chk({pre, " latency"}, n, b == 0 ? 1 : W + 1);
      chk({pre, " busy_during"}, 32'(bz), 1);
      chk({pre, " busy_at_done"}, 32'(busy), 0);
      chk({pre, " quotient"}, quotient, eq);
      chk({pre, " remainder"}, remainder, er);
      chk({pre, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
      chk({pre, " overflow"}, 32'(overflow), 32'(eov));
      @(negedge clk);
      chk({pre, " done_pulse"}, 32'(done), 0);
   endtask
   initial begin
      int n, t1, t2, n_done, a, b, sel;
      rst   = 1'b1;
      start = 1'b0;
      in1   = '0;
      in2   = '0;
      repeat (3) @(negedge clk);
      chk("reset quotient", quotient, 0);
      chk("reset remainder", remainder, 0);
      chk("reset flags", {28'b0, busy, done, div_by_zero, overflow}, 0);
      rst = 1'b0;
      run(10, 3);
      run(-10, 3);
      run(-660, -5);
      run(660, -5);
      run(7, 0);
      run(MIN, -1);
      run(32'h7FFFFFFF, 1);
      run(0, 9);
      run(MIN, 0);
      run(MIN, 1);
      for (int i = 0; i < 20; i++) begin
         sel = int'($urandom_range(0, 7));
         a   = sel == 7 ? MIN : int'($urandom);
         b   = sel == 0 ? 0 : sel == 1 ? -1 : sel == 2 ? int'($urandom_range(1, 15)) :
               sel == 3 ? -int'($urandom_range(1, 15)) : int'($urandom);
         run(a, b);
      end
      // start held high with operands swapped mid-operation
      @(negedge clk);
      in1   = 100;
      in2   = 7;
      start = 1'b1;
      @(negedge clk);
      in1 = -50;
      in2 = 4;
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      t1 = cyc;
      chk("hold first quotient", quotient, 14);
      chk("hold first remainder", remainder, 2);
      @(negedge clk);
      n = 1;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      t2 = cyc;
      start = 1'b0;
      chk("hold done spacing", t2 - t1, W + 2);
      chk("hold second quotient", quotient, -12);
      chk("hold second remainder", remainder, -2);
      // abort a division with reset
      @(negedge clk);
      in1   = 1000;
      in2   = 3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort quotient", quotient, 0);
      chk("abort remainder", remainder, 0);
      chk("abort flags", {28'b0, busy, done, div_by_zero, overflow}, 0);
      n_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) n_done++;
      end
      chk("abort no done", n_done, 0);
      run(1000, 3);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
